// File: rtl/uart_wb_host.sv
// Wishbone host sequencer for the UART: buffers TX words in a FIFO, writes them to the
// TX register when the transmitter is idle, and reads flagged RX words onto an output stream.
module uart_wb_host #(
  parameter int unsigned G_WORD_WIDTH   = 8,
  parameter int unsigned G_FIFO_DEPTH   = 8,
  parameter int unsigned G_BUSY_TIMEOUT = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_tx_valid,
  input  logic [G_WORD_WIDTH-1:0]         i_tx_data,
  output logic                            o_tx_ready,
  output logic [$clog2(G_FIFO_DEPTH):0]   o_tx_level,
  output logic                            o_rx_valid,
  output logic [G_WORD_WIDTH-1:0]         o_rx_data,
  input  logic                            i_rx_ready,
  output logic                            o_rx_overrun,
  output logic                            o_wb_we,
  output logic                            o_wb_stb,
  output logic                            o_wb_addr,
  output logic [G_WORD_WIDTH-1:0]         o_wb_data,
  input  logic                            i_wb_ack,
  input  logic [G_WORD_WIDTH-1:0]         i_wb_data,
  input  logic                            i_tx_busy,
  input  logic                            i_data_valid
);

  localparam int unsigned AW = $clog2(G_FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(G_BUSY_TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TX_WR   = 2'd1;
  localparam logic [1:0] S_TX_WAIT = 2'd2;
  localparam logic [1:0] S_RX_RD   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic [G_WORD_WIDTH-1:0] mem_q [G_FIFO_DEPTH];
  logic                    dv_q, dv_prev_q;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic                    rx_valid_q, rx_valid_d;
  logic [G_WORD_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                    stb_q, stb_d, we_q, we_d, addr_q, addr_d;
  logic [G_WORD_WIDTH-1:0] wdat_q, wdat_d;

  logic full_c, empty_c, push_c, pop_c, rise_c, rx_clr_c;
  logic [G_WORD_WIDTH-1:0] head_c;

  // FIFO status from the extra wrap bit of each pointer
  assign empty_c  = (wr_ptr_q == rd_ptr_q);
  assign full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_c   = i_tx_valid & ~full_c;
  assign pop_c    = (state_q == S_TX_WR) & i_wb_ack;
  assign head_c   = mem_q[rd_ptr_q[AW-1:0]];
  assign rise_c   = dv_q & ~dv_prev_q;
  assign rx_clr_c = (state_q == S_RX_RD) & i_wb_ack;

  assign o_tx_ready   = ~full_c;
  assign o_tx_level   = level_q;
  assign o_rx_valid   = rx_valid_q;
  assign o_rx_data    = rx_data_q;
  assign o_rx_overrun = overrun_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_we      = we_q;
  assign o_wb_addr    = addr_q;
  assign o_wb_data    = wdat_q;

  always_ff @(posedge i_clk) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= i_tx_data;
  end

  always_comb begin
    level_d = level_q;
    if (push_c && !pop_c)      level_d = level_q + LW'(1);
    else if (pop_c && !push_c) level_d = level_q - LW'(1);
  end

  // A new flag survives a coincident clear; a flag arriving on a still-pending word is lost
  always_comb begin
    pending_d = rise_c | (pending_q & ~rx_clr_c);
    overrun_d = rise_c & pending_q & ~rx_clr_c;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_valid_d = rx_valid_q & ~i_rx_ready;
    rx_data_d  = rx_data_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q && !rx_valid_q)       state_d = S_RX_RD;
        else if (!empty_c && !i_tx_busy)   state_d = S_TX_WR;
      end
      S_TX_WR: begin
        if (i_wb_ack) begin
          state_d = S_TX_WAIT;
          cnt_d   = '0;
        end
      end
      S_TX_WAIT: begin
        if (i_tx_busy || cnt_q == CW'(G_BUSY_TIMEOUT - 1)) state_d = S_IDLE;
        else                                              cnt_d   = cnt_q + CW'(1);
      end
      S_RX_RD: begin
        if (i_wb_ack) begin
          rx_data_d  = i_wb_data;
          rx_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Bus outputs registered alongside the state so they carry no decode glitches
    stb_d  = (state_d == S_TX_WR) || (state_d == S_RX_RD);
    we_d   = (state_d == S_TX_WR);
    addr_d = (state_d == S_RX_RD);
    wdat_d = (state_d == S_TX_WR) ? head_c : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      dv_q       <= 1'b0;
      dv_prev_q  <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 1'b0;
      wdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + LW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + LW'(1);
      level_q    <= level_d;
      dv_q       <= i_data_valid;
      dv_prev_q  <= dv_q;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
    end
  end

endmodule

// File: tb/tb_uart_wb_host.sv
// Scoreboard bench for uart_wb_host: Wishbone slave/UART model on the falling edge,
// queue-based reference for FIFO contents, occupancy and RX delivery.
module tb_uart_wb_host;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, rx_ready, wb_ack, tx_busy, data_valid;
  logic [7:0] tx_data, wb_rdata;
  logic       o_tx_ready, o_rx_valid, o_rx_overrun, o_wb_we, o_wb_stb, o_wb_addr;
  logic [3:0] o_tx_level;
  logic [7:0] o_rx_data, o_wb_data;

  int unsigned checks = 0, failures = 0;
  logic [7:0]  tx_q[$], rx_q[$];
  bit          ops[$];
  int          model_lvl = 0, ack_wait = 0, fixed_wait = -1;
  bit          ack_hold = 0, hold_pending = 0, prev_ovr = 0;
  logic [7:0]  held_data, uart_rx_word = 8'h00;
  int          writes_seen = 0, reads_seen = 0, overruns_seen = 0;

  uart_wb_host dut (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(tx_valid), .i_tx_data(tx_data),
    .o_tx_ready(o_tx_ready), .o_tx_level(o_tx_level), .o_rx_valid(o_rx_valid),
    .o_rx_data(o_rx_data), .i_rx_ready(rx_ready), .o_rx_overrun(o_rx_overrun),
    .o_wb_we(o_wb_we), .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(wb_ack), .i_wb_data(wb_rdata), .i_tx_busy(tx_busy), .i_data_valid(data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wishbone slave first, then the scoreboard, both on the falling edge
  always @(negedge clk) begin
    bit accept, pop;
    if (rst || !o_wb_stb) begin
      wb_ack   = 1'b0;
      ack_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
    end else if (!ack_hold) begin
      if (ack_wait == 0) begin
        wb_ack   = 1'b1;
        wb_rdata = uart_rx_word;
      end else ack_wait--;
    end
    if (!rst) begin
      check("tx_level", 32'(o_tx_level), 32'(model_lvl));
      check("tx_ready", 32'(o_tx_ready), 32'(model_lvl < DEPTH));
      accept = tx_valid && (model_lvl < DEPTH);
      if (accept) tx_q.push_back(tx_data);
      pop = 0;
      if (o_wb_stb && wb_ack) begin
        if (o_wb_we) begin
          writes_seen++;
          ops.push_back(1'b1);
          check("wr_addr", 32'(o_wb_addr), 32'd0);
          if (tx_q.size() == 0) fail_now("wr_unexpected");
          else check("wr_data", 32'(o_wb_data), 32'(tx_q.pop_front()));
          pop = 1;
        end else begin
          reads_seen++;
          ops.push_back(1'b0);
          check("rd_addr", 32'(o_wb_addr), 32'd1);
        end
      end
      if (!o_wb_stb) check("wb_quiet", {23'd0, o_wb_we, o_wb_addr, o_wb_data}, 32'd0);
      model_lvl = model_lvl + int'(accept) - int'(pop);
      if (hold_pending) check("rx_hold", {23'd0, o_rx_valid, o_rx_data}, {23'd0, 1'b1, held_data});
      hold_pending = o_rx_valid && !rx_ready;
      held_data    = o_rx_data;
      if (o_rx_valid && rx_ready) begin
        if (rx_q.size() == 0) fail_now("rx_unexpected");
        else check("rx_data", 32'(o_rx_data), 32'(rx_q.pop_front()));
      end
      if (o_rx_overrun) begin
        overruns_seen++;
        if (prev_ovr) fail_now("overrun_width");
      end
      prev_ovr = o_rx_overrun;
    end
  end

  task automatic rise(input logic [7:0] w, input bit expect_out);
    uart_rx_word = w;
    if (expect_out) rx_q.push_back(w);
    data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int mark, rd0, wr0;
    rst = 1'b1; tx_valid = 0; tx_data = 0; rx_ready = 0; tx_busy = 0; data_valid = 0;
    wb_ack = 0; wb_rdata = 0;
    repeat (3) cyc();
    check("rst_tx_ready", 32'(o_tx_ready), 32'd1);
    check("rst_level", 32'(o_tx_level), 32'd0);
    check("rst_rx", {22'd0, o_rx_valid, o_rx_overrun, o_rx_data}, 32'd0);
    check("rst_wb", {21'd0, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data}, 32'd0);
    rst = 1'b0;
    cyc();

    // Single write of 0xA5 with a two-cycle ack delay
    fixed_wait = 2;
    wr0 = writes_seen;
    tx_valid = 1; tx_data = 8'hA5; cyc(); tx_valid = 0;
    for (int i = 0; i < 30 && (tx_q.size() != 0 || o_wb_stb); i++) cyc();
    check("a5_writes", 32'(writes_seen - wr0), 32'd1);
    tx_busy = 1; cyc(); cyc(); tx_busy = 0;
    repeat (6) cyc();
    fixed_wait = -1;

    // Fill past depth while busy, then drain in order
    tx_busy = 1;
    for (int i = 0; i < 9; i++) begin
      tx_valid = 1; tx_data = 8'(8'h10 + i); cyc();
    end
    tx_valid = 0;
    cyc();
    check("full_ready", 32'(o_tx_ready), 32'd0);
    check("full_level", 32'(o_tx_level), 32'd8);
    check("full_stb", 32'(o_wb_stb), 32'd0);
    tx_busy = 0;
    for (int i = 0; i < 300 && tx_q.size() != 0; i++) cyc();
    check("drain_empty", 32'(tx_q.size()), 32'd0);
    repeat (8) cyc();

    // RX word held until the consumer is ready
    rx_ready = 0;
    rise(8'h3C, 1);
    for (int i = 0; i < 20 && !o_rx_valid; i++) cyc();
    check("rx_valid", 32'(o_rx_valid), 32'd1);
    check("rx_3c", 32'(o_rx_data), 32'h3C);
    repeat (3) cyc();
    check("rx_still", {23'd0, o_rx_valid, o_rx_data}, {23'd0, 1'b1, 8'h3C});
    rx_ready = 1;
    cyc();
    check("rx_cleared", 32'(o_rx_valid), 32'd0);
    repeat (3) cyc();

    // Pending RX and non-empty FIFO in the same IDLE cycle: read goes first
    tx_busy = 1;
    tx_valid = 1; tx_data = 8'h61; cyc(); tx_data = 8'h62; cyc(); tx_valid = 0;
    repeat (3) cyc();
    mark = ops.size();
    uart_rx_word = 8'h5A; rx_q.push_back(8'h5A);
    data_valid = 1; cyc();
    data_valid = 0; cyc();
    tx_busy = 0;
    for (int i = 0; i < 100 && ops.size() < mark + 3; i++) cyc();
    if (ops.size() < mark + 3) fail_now("prio_timeout");
    else begin
      check("prio_first_read", 32'(ops[mark]), 32'd0);
      check("prio_then_write", 32'(ops[mark+1]), 32'd1);
    end
    repeat (8) cyc();

    // Overrun: a flag arrives while one word is held and another is pending
    rx_ready = 0;
    rise(8'h11, 1);
    for (int i = 0; i < 20 && !o_rx_valid; i++) cyc();
    rise(8'h22, 0);
    repeat (3) cyc();
    rise(8'h33, 1);
    repeat (3) cyc();
    check("ovr_count", 32'(overruns_seen), 32'd1);
    rd0 = reads_seen;
    rx_ready = 1;
    for (int i = 0; i < 50 && rx_q.size() != 0; i++) cyc();
    repeat (4) cyc();
    check("ovr_one_read", 32'(reads_seen - rd0), 32'd1);
    check("ovr_rx_empty", 32'(rx_q.size()), 32'd0);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      tx_busy  = ($urandom_range(0, 3) == 0);
      rx_ready = 1'($urandom_range(0, 1));
      if (rx_q.size() == 0 && data_valid == 0 && $urandom_range(0, 7) == 0) begin
        uart_rx_word = 8'($urandom);
        rx_q.push_back(uart_rx_word);
        data_valid = 1;
      end else data_valid = 0;
      cyc();
    end
    tx_valid = 0; data_valid = 0; tx_busy = 0; rx_ready = 1;
    for (int i = 0; i < 500 && (tx_q.size() != 0 || rx_q.size() != 0); i++) cyc();
    check("rand_tx_drained", 32'(tx_q.size()), 32'd0);
    check("rand_rx_drained", 32'(rx_q.size()), 32'd0);
    check("rand_no_overrun", 32'(overruns_seen), 32'd1);
    repeat (8) cyc();

    // Asynchronous reset while a write is stalled on the bus
    tx_busy = 1;
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1; tx_data = 8'(8'hC0 + i); cyc();
    end
    tx_valid = 0;
    ack_hold = 1;
    tx_busy = 0;
    for (int i = 0; i < 20 && !o_wb_stb; i++) cyc();
    check("mid_stb", 32'(o_wb_stb), 32'd1);
    check("mid_level", 32'(o_tx_level), 32'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_stb", 32'(o_wb_stb), 32'd0);
    check("arst_we", 32'(o_wb_we), 32'd0);
    check("arst_level", 32'(o_tx_level), 32'd0);
    check("arst_ready", 32'(o_tx_ready), 32'd1);
    tx_q.delete();
    model_lvl = 0; hold_pending = 0; prev_ovr = 0;
    repeat (2) cyc();
    rst = 1'b0;
    ack_hold = 0;
    wr0 = writes_seen;
    repeat (20) cyc();
    check("arst_no_write", 32'(writes_seen - wr0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
